spi_deserializer: RTL and testbench

//  Receive-side stage downstream of the SPI serializer. Once the serializer finishes the command/address

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_edge_detect.sv | 23 ++
 rtl/spi_deserializer.sv | 131 +++++++++++++
 tb/tb_spi_deserializer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Definitions shared by the SPI serializer and deserializer: receive FSM states and default widths.
package spi_pkg;

    localparam int DEF_DATAW = 8;
    localparam int DEF_ADDRW = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX    = 2'd1,
        DRAIN = 2'd2
    } deser_state_t;

endpackage

// File: rtl/spi_edge_detect.sv
// Registers a synchronously generated strobe (spi_clk) and emits single-clk rise/fall pulses.
module spi_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;
    assign o_fall = ~i_sig & r_sig_q;

endmodule

// File: rtl/spi_deserializer.sv
// SPI read-data deserializer: samples miso on spi_clk rises and packs bits into words on a valid/ready port.
// Bit order is MSB-first by default; define DESER_LSB_FIRST_EN for LSB-first packing.
module spi_deserializer
    import spi_pkg::*;
#(
    parameter int DATAW = DEF_DATAW,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n_cs,
    input  logic             spi_clk,
    input  logic             miso,
    input  logic             rx_en,
    output logic [DATAW-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             done,
    output logic             err
);

    localparam int CNTW = $clog2(WORDS * DATAW + 1);
    localparam int WBW  = (DATAW > 1) ? $clog2(DATAW) : 1;
    localparam logic [CNTW-1:0] LAST_BIT  = CNTW'(WORDS * DATAW - 1);
    localparam logic [WBW-1:0]  LAST_WBIT = WBW'(DATAW - 1);

    deser_state_t     r_state;
    deser_state_t     w_state_next;
    logic [CNTW-1:0]  r_bit_cnt;
    logic [WBW-1:0]   r_word_bit;
    logic [DATAW-1:0] r_shift;
    logic [DATAW-1:0] w_shift_next;
    logic [DATAW-1:0] r_data_out;
    logic             r_valid_out;
    logic             r_done;
    logic             r_err;

    logic w_rise;
    logic w_fall_unused;
    logic w_start;
    logic w_abort;
    logic w_sample;
    logic w_word_done;
    logic w_last_bit;
    logic w_accept;

    spi_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (spi_clk),
        .o_rise (w_rise),
        .o_fall (w_fall_unused)
    );

`ifdef DESER_LSB_FIRST_EN
    assign w_shift_next = {miso, r_shift[DATAW-1:1]};
`else
    assign w_shift_next = {r_shift[DATAW-2:0], miso};
`endif

    assign w_accept    = r_valid_out & ready_in;
    assign w_start     = (r_state == IDLE) & rx_en & ~n_cs;
    assign w_abort     = (r_state == RX) & (n_cs | ~rx_en);
    // Abort wins over a coincident rise: the partial word is discarded anyway.
    assign w_sample    = (r_state == RX) & ~w_abort & w_rise;
    assign w_word_done = w_sample & (r_word_bit == LAST_WBIT);
    assign w_last_bit  = w_sample & (r_bit_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: assign a default first so every path drives w_state_next and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = RX;
            RX: begin
                if (w_abort)         w_state_next = IDLE;
                else if (w_last_bit) w_state_next = DRAIN;
            end
            DRAIN:   if (!r_valid_out || w_accept) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_word_bit  <= '0;
            r_shift     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN) && (w_state_next == IDLE);

            if (w_start || w_abort) begin
                r_bit_cnt  <= '0;
                r_word_bit <= '0;
                r_shift    <= '0;
                r_err      <= w_abort;
            end else if (w_sample) begin
                r_shift    <= w_shift_next;
                r_bit_cnt  <= r_bit_cnt + CNTW'(1);
                r_word_bit <= w_word_done ? '0 : r_word_bit + WBW'(1);
            end

            // A held word that is not leaving this cycle blocks the new one: drop it and flag overrun.
            if (w_word_done && (!r_valid_out || w_accept)) begin
                r_data_out  <= w_shift_next;
                r_valid_out <= 1'b1;
            end else begin
                if (w_accept)    r_valid_out <= 1'b0;
                if (w_word_done) r_err       <= 1'b1;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_spi_deserializer.sv
// Scoreboard bench for spi_deserializer (DATAW=8, WORDS=2); honours DESER_LSB_FIRST_EN for bit order.
module tb_spi_deserializer;

    localparam int DATAW = 8;
    localparam int WORDS = 2;
`ifdef DESER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             n_cs;
    logic             spi_clk;
    logic             miso;
    logic             rx_en;
    logic             ready_in;
    logic [DATAW-1:0] data_out;
    logic             valid_out;
    logic             done;
    logic             err;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    logic [DATAW-1:0] sb_q[$];
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic             prev_done  = 1'b0;
    logic [DATAW-1:0] prev_data  = '0;

    always #5 clk = ~clk;

    spi_deserializer #(.DATAW(DATAW), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .n_cs      (n_cs),
        .spi_clk   (spi_clk),
        .miso      (miso),
        .rx_en     (rx_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold/pulse rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", {31'd0, valid_out}, 32'd1);
                check("hold_data", {24'd0, data_out}, {24'd0, prev_data});
            end
            if (prev_done) check("done_1clk", {31'd0, done}, 32'd0);
            if (valid_out && ready_in) begin
                check("sb_has_entry", {31'd0, (sb_q.size() > 0)}, 32'd1);
                if (sb_q.size() > 0) check("word", {24'd0, data_out}, {24'd0, sb_q.pop_front()});
            end
            if (done) done_cnt++;
            prev_valid = valid_out;
            prev_ready = ready_in;
            prev_data  = data_out;
            prev_done  = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, input logic rdy_on_rise);
        miso    = b;
        spi_clk = 1'b0;
        tick();
        tick();
        spi_clk = 1'b1;
        if (rdy_on_rise) ready_in = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input bit chk_lat);
        for (int i = 0; i < 8; i++) begin
            spi_bit(LSB ? d[i] : d[7-i], 1'b0);
            if (chk_lat && i == 6) check("lat_before_8th", {31'd0, valid_out}, 32'd0);
            if (chk_lat && i == 7) check("lat_after_8th", {31'd0, valid_out}, 32'd1);
        end
    endtask

    task automatic start_burst();
        n_cs  = 1'b0;
        rx_en = 1'b1;
        tick();
        tick();
    endtask

    task automatic stop_burst();
        n_cs  = 1'b1;
        rx_en = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 40 && done_cnt < target; i++) tick();
        check("done_cnt", done_cnt, target);
    endtask

    initial begin
        logic [15:0] raw;
        logic [7:0]  raw_exp;
        int          done_before;

        rst = 1'b1; n_cs = 1'b1; spi_clk = 1'b0; miso = 1'b0; rx_en = 1'b0; ready_in = 1'b0;
        tick(); tick();
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick(); tick();

        // 1: back-to-back words, consumer always ready
        ready_in = 1'b1;
        sb_q.push_back(8'hA5); sb_q.push_back(8'h3C);
        start_burst();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        stop_burst();
        wait_done(1);
        check("t1_err", {31'd0, err}, 32'd0);

        // 2: consumer stalls 3 clks on word 1, word 2 not yet complete
        ready_in = 1'b0;
        sb_q.push_back(8'hA5); sb_q.push_back(8'h3C);
        start_burst();
        send_byte(8'hA5, 1'b0);
        check("t2_valid", {31'd0, valid_out}, 32'd1);
        tick(); tick(); tick();
        ready_in = 1'b1;
        send_byte(8'h3C, 1'b0);
        stop_burst();
        wait_done(2);
        check("t2_err", {31'd0, err}, 32'd0);

        // 3: overrun drops word 2, done only after word 1 leaves
        ready_in = 1'b0;
        sb_q.push_back(8'hA5);
        start_burst();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        stop_burst();
        tick(); tick();
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_valid", {31'd0, valid_out}, 32'd1);
        check("t3_data", {24'd0, data_out}, 32'h0000_00A5);
        check("t3_no_done_yet", done_cnt, 2);
        ready_in = 1'b1;
        wait_done(3);

        // 4: abort after 5 bits, then a clean burst
        ready_in = 1'b1;
        start_burst();
        for (int i = 0; i < 5; i++) spi_bit(LSB ? raw_bit(8'hA5, i) : raw_bit(8'hA5, 7 - i), 1'b0);
        n_cs = 1'b1;
        tick(); tick(); tick();
        done_before = done_cnt;
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_valid", {31'd0, valid_out}, 32'd0);
        check("t4_no_done", done_cnt, 3);
        sb_q.push_back(8'hA5); sb_q.push_back(8'h3C);
        start_burst();
        check("t4_err_cleared", {31'd0, err}, 32'd0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        stop_burst();
        wait_done(done_before + 1);

        // 5: asynchronous reset mid-burst with a word held
        ready_in = 1'b0;
        start_burst();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0);
        check("t5_valid_before", {31'd0, valid_out}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_data", {24'd0, data_out}, 32'd0);
        check("t5_rst_valid", {31'd0, valid_out}, 32'd0);
        check("t5_rst_err", {31'd0, err}, 32'd0);
        check("t5_rst_done", {31'd0, done}, 32'd0);
        stop_burst();
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        ready_in = 1'b1;
        sb_q.push_back(8'hA5); sb_q.push_back(8'h3C);
        start_burst();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        stop_burst();
        wait_done(5);
        check("t5_err", {31'd0, err}, 32'd0);

        // 6: raw bit streams; bit order decides which end the first bit lands in
        raw     = 16'b1100_0000_1010_0101;
        raw_exp = LSB ? 8'h03 : 8'hC0;
        ready_in = 1'b1;
        sb_q.push_back(raw_exp); sb_q.push_back(8'hA5);
        start_burst();
        for (int i = 0; i < 16; i++) spi_bit(raw[15-i], 1'b0);
        stop_burst();
        wait_done(6);

        // 7: accept of word 1 coincides with completion of word 2
        ready_in = 1'b0;
        sb_q.push_back(8'hA5); sb_q.push_back(8'h3C);
        start_burst();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 7; i++) spi_bit(LSB ? raw_bit(8'h3C, i) : raw_bit(8'h3C, 7 - i), 1'b0);
        spi_bit(LSB ? raw_bit(8'h3C, 7) : raw_bit(8'h3C, 0), 1'b1);
        check("t7_valid", {31'd0, valid_out}, 32'd1);
        check("t7_data", {24'd0, data_out}, 32'h0000_003C);
        check("t7_err", {31'd0, err}, 32'd0);
        stop_burst();
        wait_done(7);

        tick(); tick();
        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic raw_bit(input logic [7:0] d, input int idx);
        return d[idx];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
